chan_mux_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and two selection modes: direct select and round-robin scan. It is the sequential successor to the 16:1 bit multiplexer. It sits between multiple producer streams and a single consumer, and provides fair arbitration, backpressure and a one-cycle registered output.

---
 rtl/chan_mux_rr_pkg.sv | 17 +
 rtl/chan_mux_rr_if.sv | 31 +++
 rtl/chan_mux_rr_arb.sv | 25 ++
 rtl/chan_mux_rr.sv | 121 ++++++++++++
 tb/tb_chan_mux_rr.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/chan_mux_rr_pkg.sv
// Shared types and default sizes for the round-robin channel multiplexer.
package chan_mux_pkg;

  localparam int CHAN_N_DEF = 16;
  localparam int CHAN_W_DEF = 8;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/chan_mux_rr_if.sv
// Producer/consumer bus of the channel multiplexer. The slave modport is the
// multiplexer's view; the master modport is the surrounding logic's view.
interface chan_mux_rr_if
  import chan_mux_pkg::*;
#(
  parameter int N     = CHAN_N_DEF,
  parameter int W     = CHAN_W_DEF,
  parameter int SEL_W = $clog2(N)
);

  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/chan_mux_rr_arb.sv
// Rotate-priority search: the first requester after ptr (modulo N) wins.
module rr_arbiter #(
  parameter int N     = 16,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_found
);

  // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1) so
  // the last hit, which is the closest one after ptr, is the winner.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_idx   = SEL_W'((int'(ptr) + k) % N);
        gnt_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered multiplexer with direct-select and round-robin modes.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | output register holds no word (out_valid=0)
// ST_FULL  | output register holds a word  (out_valid=1)
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter int N     = CHAN_N_DEF,
  parameter int W     = CHAN_W_DEF,
  parameter int SEL_W = $clog2(N)
) (
  input logic         clk,
  input logic         rst,
  chan_mux_rr_if.slave bus
);

  out_state_e              state_q, state_d;
  logic [SEL_W-1:0]        ptr_q;
  logic [SEL_W-1:0]        out_chan_q;
  logic [W-1:0]            out_data_q;

  mux_mode_e               mode_e;
  logic [(1<<SEL_W)-1:0]   valid_pad;
  logic                    sel_in_range;
  logic                    sel_found;
  logic [SEL_W-1:0]        rr_idx;
  logic                    rr_found;
  logic [SEL_W-1:0]        gnt_idx;
  logic                    gnt_found;
  logic                    load_en;
  logic                    do_load;
  logic [N-1:0]            in_ready_c;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .gnt_idx   (rr_idx),
    .gnt_found (rr_found)
  );

  // A select code past the last channel (non-power-of-two N) never grants.
  assign sel_in_range = ({1'b0, bus.sel} < (SEL_W+1)'(N));

  // Pick the granted channel for the active mode.
  always_comb begin
    mode_e               = mux_mode_e'(bus.mode);
    valid_pad            = '0;
    valid_pad[N-1:0]     = bus.in_valid;
    sel_found            = sel_in_range & valid_pad[bus.sel];
    if (mode_e == MODE_RR) begin
      gnt_idx   = rr_idx;
      gnt_found = rr_found;
    end else begin
      gnt_idx   = bus.sel;
      gnt_found = sel_found;
    end
  end

  // Reset blocks any handshake so no transfer is reported while it is high.
  assign load_en = (state_q == ST_EMPTY) | bus.out_ready;
  assign do_load = ~rst & load_en & gnt_found;

  // One-hot ready toward the granted producer only.
  always_comb begin
    in_ready_c = '0;
    if (do_load) begin
      in_ready_c[gnt_idx] = 1'b1;
    end
  end

  // Output register occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill on a transfer, drain when the consumer takes the word and nothing refills it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (do_load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.out_ready && !do_load) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Capture the granted word and remember the served channel for the next scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q      <= SEL_W'(N - 1);
    end else if (do_load) begin
      out_data_q <= bus.in_data[gnt_idx*W +: W];
      out_chan_q <= gnt_idx;
      ptr_q      <= gnt_idx;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_chan_mux_rr.sv
// Bench for chan_mux_rr: a behavioural model checked every cycle plus
// directed scenarios with literal expectations, then a randomized phase.
module tb_chan_mux_rr;
  import chan_mux_pkg::*;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int SEL_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  chan_mux_rr_if #(.N(N), .W(W)) bus ();

  chan_mux_rr #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the output register must hold and the last served channel.
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_chan  = 0;
  int m_ptr   = N - 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Granted channel from the selection rules, -1 when nobody qualifies.
  function automatic int model_grant();
    int c;
    if (bus.mode == 1'b0) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  // Compare every cycle mid-period, then advance the model to the next edge.
  always @(negedge clk) begin
    int  g;
    int  exp_rdy;
    bit  load;
    g       = model_grant();
    load    = !rst && (!m_valid || bus.out_ready) && (g >= 0);
    exp_rdy = load ? (1 << g) : 0;
    chk("in_ready",  int'(bus.in_ready),  exp_rdy);
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("out_data",  int'(bus.out_data),  m_data);
    chk("out_chan",  int'(bus.out_chan),  m_chan);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_chan  = 0;
      m_ptr   = N - 1;
    end else if (load) begin
      m_valid = 1'b1;
      m_data  = int'(bus.in_data[g*W +: W]);
      m_chan  = g;
      m_ptr   = g;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic data_pattern();
    for (int c = 0; c < N; c++) bus.in_data[c*W +: W] = W'(8'hA0 + c);
  endtask

  task automatic data_random();
    for (int c = 0; c < N; c++) bus.in_data[c*W +: W] = W'($urandom);
  endtask

  initial begin
    int exp_d;
    rst           = 1'b1;
    bus.in_valid  = '1;
    bus.mode      = 1'b1;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    data_pattern();

    // Reset for two cycles with every channel valid.
    tick();
    tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    rst = 1'b0;
    #1;
    chk("rr_first_ready", int'(bus.in_ready), 16'h0001);
    tick();
    chk("rr_first_chan",  int'(bus.out_chan),  0);
    chk("rr_first_valid", int'(bus.out_valid), 1);

    // Direct-select sweep, granted then blocked.
    bus.mode = 1'b0;
    for (int s = 0; s < N; s++) begin
      bus.sel      = SEL_W'(s);
      bus.in_valid = N'(1 << s);
      tick();
      chk("sel_data", int'(bus.out_data), 8'hA0 + s);
      chk("sel_chan", int'(bus.out_chan), s);
    end
    for (int s = 0; s < N; s++) begin
      bus.sel      = SEL_W'(s);
      bus.in_valid = ~N'(1 << s);
      #1;
      chk("sel_block_ready", int'(bus.in_ready), 0);
      tick();
      chk("sel_block_valid", int'(bus.out_valid), 0);
    end

    // Round-robin fairness, then two sparse requesters.
    bus.mode     = 1'b1;
    bus.in_valid = '1;
    for (int i = 0; i < 2*N; i++) begin
      tick();
      chk("rr_fair_chan", int'(bus.out_chan), i % N);
    end
    bus.in_valid = N'((1 << 3) | (1 << 9));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_alt_chan", int'(bus.out_chan), (i % 2) ? 9 : 3);
    end

    // Backpressure while holding channel 5.
    data_pattern();
    bus.mode     = 1'b0;
    bus.sel      = SEL_W'(5);
    bus.in_valid = '1;
    tick();
    chk("bp_load_chan", int'(bus.out_chan), 5);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_random();
      bus.sel = SEL_W'($urandom_range(0, N-1));
      #1;
      chk("bp_ready", int'(bus.in_ready), 0);
      tick();
      chk("bp_hold_chan", int'(bus.out_chan), 5);
      chk("bp_hold_data", int'(bus.out_data), 8'hA5);
    end
    bus.out_ready = 1'b1;
    bus.sel       = SEL_W'(6);
    #1;
    chk("bp_release_ready", int'(bus.in_ready), 1 << 6);
    exp_d = int'(bus.in_data[6*W +: W]);
    tick();
    chk("bp_next_chan",  int'(bus.out_chan),  6);
    chk("bp_next_data",  int'(bus.out_data),  exp_d);
    chk("bp_next_valid", int'(bus.out_valid), 1);

    // Wrap past the last channel and mode switches.
    data_pattern();
    bus.sel = SEL_W'(15);
    tick();
    bus.mode     = 1'b1;
    bus.in_valid = N'((1 << 0) | (1 << 15));
    tick();
    chk("wrap_chan", int'(bus.out_chan), 0);
    bus.mode     = 1'b0;
    bus.sel      = SEL_W'(7);
    bus.in_valid = N'(1 << 7);
    tick();
    chk("switch_sel_chan", int'(bus.out_chan), 7);
    bus.mode     = 1'b1;
    bus.in_valid = '1;
    tick();
    chk("switch_rr_chan", int'(bus.out_chan), 8);

    // Reset pulse while full and stalled.
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("mid_rst_chan", int'(bus.out_chan), 0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.in_valid  = ($urandom_range(0, 1) == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      bus.mode      = 1'($urandom_range(0, 1));
      bus.sel       = SEL_W'($urandom_range(0, N-1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      data_random();
      tick();
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
